rob_mc: RTL and testbench

- Parametrised reorder buffer, successor to the single-writeback-port ROB.
- Sits between decoder (issue), RS/LSB/ALU (writeback channels), regfile (commit) and ifetch (redirect, predictor update).
- Adds configurable depth, N writeback channels, explicit occupancy count and a store-commit handshake with the LSB.
- Retires one instruction per cycle in order and flushes on branch mispredict.

---
 rtl/rob_mc.sv | 249 ++++++++++++++++++++++++
 tb/tb_rob_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mc.sv
// rob_mc - parametrised reorder buffer.
// Allocates entries in program order from the decoder and accepts results
// on WB_CH writeback channels. It retires at most one instruction per cycle,
// in order, to the regfile. It performs the store-commit handshake with the
// LSB and resolves branches at retire, flushing everything on a mispredict.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global pause)
//   issue_*          : allocation request at tail (full/free_id/count back)
//   q1_*/q2_*        : operand lookup by entry id (combinational)
//   wb_*             : flat per-channel writeback (channel k at slice k)
//   head_id, st_ready_in, st_commit : store retirement handshake with LSB
//   commit_*         : registered regfile write pulse
//   redirect*, bp_*  : registered fetch redirect / predictor update pulses
//   flush, halt      : squash pulse, sticky stop after exit op
module rob_mc #(
  parameter int DEPTH = 16,
  parameter int IDW   = 4,
  parameter int WB_CH = 3,
  parameter int RW    = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  input  logic [5:0]            issue_op,
  input  logic [RW-1:0]         issue_rd,
  input  logic [31:0]           issue_imm,
  input  logic [31:0]           issue_pc,
  input  logic                  issue_pred,
  input  logic                  issue_is_store,
  output logic                  full,
  output logic [IDW-1:0]        free_id,
  output logic [IDW:0]          count,
  input  logic [IDW-1:0]        q1_id,
  input  logic [IDW-1:0]        q2_id,
  output logic                  q1_ready,
  output logic                  q2_ready,
  output logic [31:0]           q1_value,
  output logic [31:0]           q2_value,
  input  logic [WB_CH-1:0]      wb_valid,
  input  logic [WB_CH*IDW-1:0]  wb_id,
  input  logic [WB_CH*32-1:0]   wb_value,
  input  logic [WB_CH*32-1:0]   wb_npc,
  output logic [IDW-1:0]        head_id,
  input  logic                  st_ready_in,
  output logic                  st_commit,
  output logic                  commit_en,
  output logic [RW-1:0]         commit_rd,
  output logic [IDW-1:0]        commit_id,
  output logic [31:0]           commit_value,
  output logic                  redirect,
  output logic [31:0]           redirect_pc,
  output logic                  bp_update,
  output logic [31:0]           bp_pc,
  output logic                  bp_pred,
  output logic                  bp_taken,
  output logic                  flush,
  output logic                  halt
);

  localparam logic [IDW:0] LP_FULL = (IDW+1)'(DEPTH);
  localparam logic [5:0]   OP_JALR = 6'd3;
  localparam logic [5:0]   OP_BR_LO = 6'd4;
  localparam logic [5:0]   OP_BR_HI = 6'd9;
  localparam logic [5:0]   OP_EXIT = 6'd39;

  // Control state (reset)
  logic           r_valid [DEPTH];
  logic           r_done  [DEPTH];
  logic [IDW-1:0] r_head, r_tail;
  logic [IDW:0]   r_count;
  logic           r_halt;

  // Entry payload (no reset; qualified by r_valid/r_done)
  logic [5:0]     r_op    [DEPTH];
  logic [RW-1:0]  r_rd    [DEPTH];
  logic [31:0]    r_imm   [DEPTH];
  logic [31:0]    r_pc    [DEPTH];
  logic           r_pred  [DEPTH];
  logic           r_store [DEPTH];
  logic [31:0]    r_value [DEPTH];
  logic [31:0]    r_npc   [DEPTH];

  // Registered outputs
  logic           r_st_commit, r_commit_en, r_redirect, r_bp_update, r_flush;
  logic           r_bp_pred, r_bp_taken;
  logic [RW-1:0]  r_commit_rd;
  logic [IDW-1:0] r_commit_id;
  logic [31:0]    r_commit_value, r_redirect_pc, r_bp_pc;

  logic           w_issue, w_retire, w_mispred;
  logic           w_is_exit, w_is_jalr, w_is_br, w_taken;
  logic [5:0]     w_op;
  logic [IDW:0]   w_count_nxt;
  logic [IDW-1:0] w_wb_id  [WB_CH];
  logic           w_wb_hit [WB_CH];

  function automatic logic [31:0] f_br_target(input logic [31:0] pc,
                                              input logic [31:0] imm,
                                              input logic        taken);
    f_br_target = pc + (taken ? imm : 32'd4);
  endfunction

  always_comb begin
    w_op      = r_op[r_head];
    w_is_exit = (w_op == OP_EXIT);
    w_is_jalr = (w_op == OP_JALR);
    w_is_br   = (w_op >= OP_BR_LO) && (w_op <= OP_BR_HI);
    w_taken   = (r_value[r_head] != 32'd0);
    // Stores additionally wait for the LSB; nothing retires once halted.
    w_retire  = rdy_in && r_valid[r_head] && r_done[r_head] && !r_halt &&
                (!r_store[r_head] || st_ready_in);
    w_mispred = w_retire && w_is_br && (w_taken != r_pred[r_head]);
    // The flush edge discards any same-cycle allocation and writeback.
    w_issue   = rdy_in && issue_valid && (r_count != LP_FULL) && !w_mispred;
    w_count_nxt = r_count + (IDW+1)'(w_issue) - (IDW+1)'(w_retire);
  end

  always_comb begin
    for (int k = 0; k < WB_CH; k++) begin
      w_wb_id[k]  = wb_id[k*IDW +: IDW];
      w_wb_hit[k] = rdy_in && !w_mispred && wb_valid[k] && r_valid[w_wb_id[k]];
    end
  end

  // Control and retire stage
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_halt         <= 1'b0;
      r_st_commit    <= 1'b0;
      r_commit_en    <= 1'b0;
      r_redirect     <= 1'b0;
      r_bp_update    <= 1'b0;
      r_flush        <= 1'b0;
      r_bp_pred      <= 1'b0;
      r_bp_taken     <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_id    <= '0;
      r_commit_value <= '0;
      r_redirect_pc  <= '0;
      r_bp_pc        <= '0;
    end else begin
      r_st_commit <= 1'b0;
      r_commit_en <= 1'b0;
      r_redirect  <= 1'b0;
      r_bp_update <= 1'b0;
      r_flush     <= 1'b0;
      if (w_mispred) begin
        for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_commit_id   <= r_head;
        r_bp_update   <= 1'b1;
        r_bp_pc       <= r_pc[r_head];
        r_bp_pred     <= r_pred[r_head];
        r_bp_taken    <= w_taken;
        r_redirect    <= 1'b1;
        r_redirect_pc <= f_br_target(r_pc[r_head], r_imm[r_head], w_taken);
        r_flush       <= 1'b1;
      end else if (rdy_in) begin
        if (w_issue) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_tail          <= r_tail + 1'b1;
        end
        for (int k = 0; k < WB_CH; k++)
          if (w_wb_hit[k]) r_done[w_wb_id[k]] <= 1'b1;
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
          r_commit_id     <= r_head;
          if (r_store[r_head]) begin
            r_st_commit <= 1'b1;
          end else if (w_is_exit) begin
            r_halt <= 1'b1;
          end else begin
            r_commit_en    <= 1'b1;
            r_commit_rd    <= r_rd[r_head];
            r_commit_value <= r_value[r_head];
            if (w_is_jalr) begin
              r_redirect    <= 1'b1;
              r_redirect_pc <= r_npc[r_head];
            end
            if (w_is_br) begin
              r_bp_update <= 1'b1;
              r_bp_pc     <= r_pc[r_head];
              r_bp_pred   <= r_pred[r_head];
              r_bp_taken  <= w_taken;
            end
          end
        end
        r_count <= w_count_nxt;
      end
    end
  end

  // Entry payload stage: allocation then writeback (highest channel wins)
  always_ff @(posedge clk_in) begin
    if (w_issue) begin
      r_op[r_tail]    <= issue_op;
      r_rd[r_tail]    <= issue_rd;
      r_imm[r_tail]   <= issue_imm;
      r_pc[r_tail]    <= issue_pc;
      r_pred[r_tail]  <= issue_pred;
      r_store[r_tail] <= issue_is_store;
      r_value[r_tail] <= 32'd0;
      r_npc[r_tail]   <= 32'd0;
    end
    for (int k = 0; k < WB_CH; k++) begin
      if (w_wb_hit[k]) begin
        r_value[w_wb_id[k]] <= wb_value[k*32 +: 32];
        r_npc[w_wb_id[k]]   <= wb_npc[k*32 +: 32];
      end
    end
  end

  assign full     = (r_count == LP_FULL);
  assign free_id  = r_tail;
  assign count    = r_count;
  assign head_id  = r_head;
  assign q1_ready = !r_valid[q1_id] || r_done[q1_id];
  assign q2_ready = !r_valid[q2_id] || r_done[q2_id];
  assign q1_value = (r_valid[q1_id] && r_done[q1_id]) ? r_value[q1_id] : 32'd0;
  assign q2_value = (r_valid[q2_id] && r_done[q2_id]) ? r_value[q2_id] : 32'd0;

  assign st_commit    = r_st_commit;
  assign commit_en    = r_commit_en;
  assign commit_rd    = r_commit_rd;
  assign commit_id    = r_commit_id;
  assign commit_value = r_commit_value;
  assign redirect     = r_redirect;
  assign redirect_pc  = r_redirect_pc;
  assign bp_update    = r_bp_update;
  assign bp_pc        = r_bp_pc;
  assign bp_pred      = r_bp_pred;
  assign bp_taken     = r_bp_taken;
  assign flush        = r_flush;
  assign halt         = r_halt;

endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc - directed bench for rob_mc (DEPTH=16, WB_CH=3).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_rob_mc;
  logic        clk_in, rst_in, rdy_in;
  logic        issue_valid, issue_pred, issue_is_store;
  logic [5:0]  issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] issue_imm, issue_pc;
  logic        full;
  logic [3:0]  free_id, q1_id, q2_id, head_id, commit_id;
  logic [4:0]  count, commit_rd;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic [2:0]  wb_valid;
  logic [11:0] wb_id;
  logic [95:0] wb_value, wb_npc;
  logic        st_ready_in, st_commit, commit_en, redirect, bp_update;
  logic        bp_pred, bp_taken, flush, halt;
  logic [31:0] commit_value, redirect_pc, bp_pc;

  int checks = 0;
  int errors = 0;

  rob_mc #(.DEPTH(16), .IDW(4), .WB_CH(3), .RW(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pred(issue_pred),
    .issue_is_store(issue_is_store), .full(full), .free_id(free_id),
    .count(count), .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready),
    .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_npc(wb_npc),
    .head_id(head_id), .st_ready_in(st_ready_in), .st_commit(st_commit),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_id(commit_id),
    .commit_value(commit_value), .redirect(redirect),
    .redirect_pc(redirect_pc), .bp_update(bp_update), .bp_pc(bp_pc),
    .bp_pred(bp_pred), .bp_taken(bp_taken), .flush(flush), .halt(halt)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_issue(input int op, input int rd, input int pc, input int imm,
                           input bit pred, input bit st);
    issue_valid = 1'b1;
    issue_op = 6'(op);
    issue_rd = 5'(rd);
    issue_pc = 32'(pc);
    issue_imm = 32'(imm);
    issue_pred = pred;
    issue_is_store = st;
  endtask

  task automatic do_issue(input int op, input int rd, input int pc, input int imm,
                          input bit pred, input bit st);
    set_issue(op, rd, pc, imm, pred, st);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic set_wb(input int ch, input int id, input int val);
    wb_valid[ch] = 1'b1;
    wb_id[ch*4 +: 4] = 4'(id);
    wb_value[ch*32 +: 32] = 32'(val);
  endtask

  task automatic clr_wb();
    wb_valid = '0;
    wb_id = '0;
    wb_value = '0;
    wb_npc = '0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; issue_valid = 1'b0; issue_op = '0;
    issue_rd = '0; issue_imm = '0; issue_pc = '0; issue_pred = 1'b0;
    issue_is_store = 1'b0; q1_id = '0; q2_id = '0; st_ready_in = 1'b0;
    clr_wb();
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_head", 32'(head_id), 0);
    chk("rst_free", 32'(free_id), 0);
    chk("rst_commit_en", 32'(commit_en), 0);
    chk("rst_halt", 32'(halt), 0);
    rst_in = 1'b1;
    tick();

    // Fill, overflow attempt, out-of-order writeback, in-order retire
    for (int i = 0; i < 16; i++) do_issue(0, i + 1, 0, 0, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 16);
    chk("fill_full", 32'(full), 1);
    do_issue(0, 31, 0, 0, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_free", 32'(free_id), 0);
    q1_id = 4'd3;
    #1;
    chk("q_pending_rdy", 32'(q1_ready), 0);
    chk("q_pending_val", q1_value, 0);
    for (int i = 15; i >= 0; i--) begin
      clr_wb();
      set_wb(i % 3, i, 100 + i);
      tick();
      if (i != 0) chk("ooo_no_commit", 32'(commit_en), 0);
    end
    clr_wb();
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("fill_commit_en", 32'(commit_en), 1);
      chk("fill_commit_id", 32'(commit_id), 32'(j));
      chk("fill_commit_val", commit_value, 32'(100 + j));
      chk("fill_commit_rd", 32'(commit_rd), 32'(j + 1));
    end
    chk("drain_count", 32'(count), 0);
    tick();
    chk("drain_idle", 32'(commit_en), 0);

    // Wrap: issue each cycle, writeback two cycles later, 3 in flight
    for (int t = 0; t <= 44; t++) begin
      clr_wb();
      if (t <= 41) set_issue(0, 2, 0, 0, 1'b0, 1'b0);
      else issue_valid = 1'b0;
      if (t >= 2 && t <= 43) set_wb(0, (t - 2) % 16, 1000 + t - 2);
      tick();
      if (t >= 3) begin
        chk("wrap_commit_en", 32'(commit_en), 1);
        chk("wrap_commit_id", 32'(commit_id), 32'((t - 3) % 16));
        chk("wrap_commit_val", commit_value, 32'(1000 + t - 3));
      end
      chk("wrap_count", 32'(count), 32'(((t <= 41) ? t + 1 : 42) - ((t >= 2) ? t - 2 : 0)));
    end
    issue_valid = 1'b0;
    clr_wb();
    chk("wrap_head", 32'(head_id), 10);

    // Mispredicted branch at id 10 with two younger finished entries
    do_issue(4, 0, 32'h100, 32'h20, 1'b0, 1'b0);
    do_issue(0, 7, 0, 0, 1'b0, 1'b0);
    do_issue(0, 8, 0, 0, 1'b0, 1'b0);
    chk("br_count", 32'(count), 3);
    set_wb(0, 11, 55);
    set_wb(1, 12, 66);
    tick();
    clr_wb();
    set_wb(2, 10, 1);
    tick();
    clr_wb();
    tick();
    chk("br_update", 32'(bp_update), 1);
    chk("br_taken", 32'(bp_taken), 1);
    chk("br_pred", 32'(bp_pred), 0);
    chk("br_pc", bp_pc, 32'h100);
    chk("br_redirect", 32'(redirect), 1);
    chk("br_redirect_pc", redirect_pc, 32'h120);
    chk("br_flush", 32'(flush), 1);
    chk("br_commit_en", 32'(commit_en), 0);
    chk("br_count0", 32'(count), 0);
    chk("br_head0", 32'(head_id), 0);
    chk("br_free0", 32'(free_id), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("br_young_none", 32'(commit_en), 0);
      chk("br_flush_pulse", 32'(flush), 0);
    end

    // Store at head waits for the LSB
    do_issue(20, 0, 0, 0, 1'b0, 1'b1);
    set_wb(0, 0, 0);
    tick();
    clr_wb();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_wait_st", 32'(st_commit), 0);
      chk("st_wait_head", 32'(head_id), 0);
    end
    st_ready_in = 1'b1;
    rdy_in = 1'b0;
    tick();
    chk("st_paused", 32'(st_commit), 0);
    chk("st_paused_head", 32'(head_id), 0);
    rdy_in = 1'b1;
    tick();
    chk("st_commit", 32'(st_commit), 1);
    chk("st_commit_en", 32'(commit_en), 0);
    chk("st_commit_id", 32'(commit_id), 0);
    chk("st_head", 32'(head_id), 1);
    st_ready_in = 1'b0;
    tick();
    chk("st_pulse_end", 32'(st_commit), 0);

    // Two channels write id 5 in one cycle: channel 2 wins
    for (int i = 1; i <= 5; i++) do_issue(0, 1, 0, 0, 1'b0, 1'b0);
    q1_id = 4'd5; q2_id = 4'd0;
    #1;
    chk("dup_pre_rdy", 32'(q1_ready), 0);
    chk("q_invalid_rdy", 32'(q2_ready), 1);
    chk("q_invalid_val", q2_value, 0);
    set_wb(0, 5, 7);
    set_wb(2, 5, 9);
    #1;
    chk("dup_no_bypass", 32'(q1_ready), 0);
    tick();
    clr_wb();
    chk("dup_rdy", 32'(q1_ready), 1);
    chk("dup_val", q1_value, 9);

    // Retire ids 1..5, then exit halts the buffer
    set_wb(0, 1, 11); set_wb(1, 2, 12); set_wb(2, 3, 13);
    tick();
    clr_wb();
    set_wb(0, 4, 14);
    tick();
    clr_wb();
    for (int i = 0; i < 4; i++) tick();
    chk("ret_commit_id", 32'(commit_id), 5);
    chk("ret_commit_val", commit_value, 9);
    chk("ret_count", 32'(count), 0);
    do_issue(39, 0, 0, 0, 1'b0, 1'b0);
    do_issue(0, 3, 0, 0, 1'b0, 1'b0);
    set_wb(0, 6, 0);
    set_wb(1, 7, 77);
    tick();
    clr_wb();
    tick();
    chk("exit_halt", 32'(halt), 1);
    chk("exit_commit_en", 32'(commit_en), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_sticky", 32'(halt), 1);
      chk("halt_no_commit", 32'(commit_en), 0);
      chk("halt_count", 32'(count), 1);
      chk("halt_head", 32'(head_id), 7);
    end

    // Asynchronous reset mid-run
    rst_in = 1'b0;
    #1;
    chk("arst_halt", 32'(halt), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_head", 32'(head_id), 0);
    chk("arst_free", 32'(free_id), 0);
    chk("arst_commit_id", 32'(commit_id), 0);
    chk("arst_commit_val", commit_value, 0);
    tick();
    rst_in = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
